// File: rtl/microcode_sequencer_if.sv
// Register-transfer bus between the microcode sequencer (master) and the fabric (slave).
// One (r_addr, w_addr) pair per accepted valid/ready handshake.
interface microcode_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              xfer_valid;
  logic              xfer_ready;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr;

  modport master (output xfer_valid, output r_addr, output w_addr, input xfer_ready);
  modport slave  (input xfer_valid, input r_addr, input w_addr, output xfer_ready);
endinterface

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: loadable micro-store stepping MOVE/jump/loop/halt micro-ops
// and issuing register-transfer requests on the fabric bus.
module microcode_sequencer #(
  parameter int ADDR_W = 8,
  parameter int UPC_W  = 6,
  parameter int COND_N = 4,
  localparam int CSEL_W = (COND_N > 1) ? $clog2(COND_N) : 1,
  localparam int UW     = 3 + CSEL_W + UPC_W + 2 * ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ucode_we,
  input  logic [UPC_W-1:0]      ucode_waddr,
  input  logic [UW-1:0]         ucode_wdata,
  input  logic                  start,
  input  logic [UPC_W-1:0]      start_upc,
  input  logic                  abort,
  input  logic [COND_N-1:0]     cond,
  microcode_sequencer_if.master xfer,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [UPC_W-1:0]      upc
);

  localparam int DEPTH  = 1 << UPC_W;
  localparam int CSEL_N = 1 << CSEL_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC
  } state_e;

  typedef enum logic [2:0] {
    OP_MOVE = 3'd0,
    OP_JMP  = 3'd1,
    OP_JMPT = 3'd2,
    OP_JMPF = 3'd3,
    OP_LDC  = 3'd4,
    OP_DJNZ = 3'd5,
    OP_HALT = 3'd6,
    OP_ILL  = 3'd7
  } op_e;

  state_e              state_q, state_d;
  logic [UPC_W-1:0]    upc_q, upc_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [UW-1:0]       mem [DEPTH];
  logic [UW-1:0]       ir_q;

  op_e                 op;
  logic [CSEL_W-1:0]   csel;
  logic [UPC_W-1:0]    target;
  logic [ADDR_W-1:0]   rf;
  logic [ADDR_W-1:0]   wf;
  logic [CSEL_N-1:0]   cond_ext;
  logic                cond_bit;
  logic [UPC_W-1:0]    upc_inc;
  logic [ADDR_W-1:0]   cnt_dec;
  logic                mem_we;
  logic                move_active;

  assign op     = op_e'(ir_q[UW-1 -: 3]);
  assign csel   = ir_q[UW-4 -: CSEL_W];
  assign target = ir_q[2*ADDR_W +: UPC_W];
  assign rf     = ir_q[ADDR_W +: ADDR_W];
  assign wf     = ir_q[0 +: ADDR_W];

  // Selects beyond the implemented flags read as a constant 0.
  for (genvar gi = 0; gi < CSEL_N; gi++) begin : g_cond
    if (gi < COND_N) begin : g_live
      assign cond_ext[gi] = cond[gi];
    end else begin : g_zero
      assign cond_ext[gi] = 1'b0;
    end
  end
  assign cond_bit = cond_ext[csel];

  assign upc_inc = upc_q + UPC_W'(1);
  assign cnt_dec = cnt_q - ADDR_W'(1);
  assign mem_we  = ucode_we && (state_q == S_IDLE);

  // Store write and synchronous read into the instruction register share one port block.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[ucode_waddr] <= ucode_wdata;
    end
    if (state_q == S_FETCH) begin
      ir_q <= mem[upc_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      upc_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            upc_d   = start_upc;
            err_d   = 1'b0;
            state_d = S_FETCH;
          end
        end
        S_FETCH: state_d = S_EXEC;
        S_EXEC: begin
          state_d = S_FETCH;
          case (op)
            OP_MOVE: begin
              if (xfer.xfer_ready) begin
                upc_d = upc_inc;
              end else begin
                state_d = S_EXEC;
              end
            end
            OP_JMP:  upc_d = target;
            OP_JMPT: upc_d = cond_bit ? target : upc_inc;
            OP_JMPF: upc_d = cond_bit ? upc_inc : target;
            OP_LDC: begin
              cnt_d = rf;
              upc_d = upc_inc;
            end
            OP_DJNZ: begin
              cnt_d = cnt_dec;
              upc_d = (cnt_dec != '0) ? target : upc_inc;
            end
            OP_HALT: begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
            default: begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              err_d   = 1'b1;
            end
          endcase
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Transfer outputs decode only registered state, so reset clears them immediately.
  assign move_active     = (state_q == S_EXEC) && (op == OP_MOVE);
  assign xfer.xfer_valid = move_active;
  assign xfer.r_addr     = move_active ? rf : '0;
  assign xfer.w_addr     = move_active ? wf : '0;

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign err  = err_q;
  assign upc  = upc_q;

endmodule
